// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter
// Per-output-port scheduler for a NoC router. Round-robin arbitration among
// NUM_IN input queues; the winning packet is latched and serialized onto the
// byte-wide put/payload link, most significant byte first.
// Optional macro ARB_STATS_EN adds per-input saturating 16-bit grant counters
// and the grant_count port.
module noc_out_port_arbiter #(
   parameter int NUM_IN    = 4,
   parameter int PKT_W     = 32,
   parameter int BYTE_W    = 8,
   parameter int NUM_BYTES = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_IN-1:0]         req,
   input  logic [NUM_IN*PKT_W-1:0]   pkt_in,
   output logic [NUM_IN-1:0]         pop,
   input  logic                      free_outbound,
   output logic                      put_outbound,
   output logic [BYTE_W-1:0]         payload_outbound,
   output logic                      busy
`ifdef ARB_STATS_EN
   ,
   output logic [NUM_IN*16-1:0]      grant_count
`endif
);

   localparam int PTR_W  = $clog2(NUM_IN);
   localparam int BCNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [PTR_W:0]    idx_t;
   typedef logic [BCNT_W-1:0] bcnt_t;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]        r_state;
   ptr_t              r_rr_ptr;
   bcnt_t             r_byte_cnt;
   logic [PKT_W-1:0]  r_shift;
   logic              r_put;
   logic [BYTE_W-1:0] r_payload;

   logic [PKT_W-1:0]  w_pkt [NUM_IN];
   logic              w_found;
   ptr_t              w_win;
   idx_t              w_idx;
   logic              w_grant;
   ptr_t              w_next_ptr;
   logic [PKT_W-1:0]  w_sel;

   // Unpack the flat head-packet bus and build the one-hot pop vector.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_in
         assign w_pkt[gi] = pkt_in[gi*PKT_W +: PKT_W];
         assign pop[gi]   = w_grant && (w_win == ptr_t'(gi));
      end
   endgenerate

   // Round-robin search: first requester starting at r_rr_ptr, modulo NUM_IN.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         w_idx = {1'b0, r_rr_ptr} + idx_t'(k);
         if (w_idx >= idx_t'(NUM_IN)) begin
            w_idx = w_idx - idx_t'(NUM_IN);
         end
         if (!w_found && req[w_idx[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[PTR_W-1:0];
         end
      end
   end

   // A grant only happens from IDLE with the link free; reset suppresses it.
   assign w_grant    = !reset && (r_state == S_IDLE) && free_outbound && w_found;
   assign w_next_ptr = (w_win == ptr_t'(NUM_IN - 1)) ? '0 : w_win + 1'b1;
   assign w_sel      = w_pkt[w_win];

   // Control FSM and serializer. r_shift holds the bytes still to be sent,
   // so the output byte register is always one step ahead of the shifter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_byte_cnt <= '0;
         r_shift    <= '0;
         r_put      <= 1'b0;
         r_payload  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_state    <= S_SEND;
                  r_rr_ptr   <= w_next_ptr;
                  r_byte_cnt <= '0;
                  r_put      <= 1'b1;
                  r_payload  <= w_sel[PKT_W-1 -: BYTE_W];
                  r_shift    <= {w_sel[PKT_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               end
            end
            S_SEND: begin
               if (r_byte_cnt == bcnt_t'(NUM_BYTES - 1)) begin
                  r_state    <= S_IDLE;
                  r_byte_cnt <= '0;
                  r_put      <= 1'b0;
                  r_payload  <= '0;
                  r_shift    <= '0;
               end else begin
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                  r_payload  <= r_shift[PKT_W-1 -: BYTE_W];
                  r_shift    <= {r_shift[PKT_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign put_outbound     = r_put;
   assign payload_outbound = r_payload;
   assign busy             = (r_state == S_SEND);

`ifdef ARB_STATS_EN
   logic [15:0] r_grant_cnt [NUM_IN];

   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_stats
         // Saturating grant counter for input gi.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_grant_cnt[gi] <= '0;
            end else if (pop[gi] && (r_grant_cnt[gi] != 16'hFFFF)) begin
               r_grant_cnt[gi] <= r_grant_cnt[gi] + 16'd1;
            end
         end
         assign grant_count[gi*16 +: 16] = r_grant_cnt[gi];
      end
   endgenerate
`endif

endmodule
